// File: rtl/pac_sprite_pkg.sv
// Shared constants for the sprite row fetch path: tile geometry, sprite ROM
// indices and render requester ids.
package pac_sprite_pkg;

   localparam int TILE_SIZE = 16;
   localparam int SPR_W     = 4;
   localparam int ROW_W     = 4;

   localparam logic [SPR_W-1:0] SPR_DOT         = 4'd0;
   localparam logic [SPR_W-1:0] SPR_BIG_DOT     = 4'd1;
   localparam logic [SPR_W-1:0] SPR_PAC_F1      = 4'd2;
   localparam logic [SPR_W-1:0] SPR_PAC_F2      = 4'd3;
   localparam logic [SPR_W-1:0] SPR_GHOST_F1    = 4'd4;
   localparam logic [SPR_W-1:0] SPR_GHOST_F2    = 4'd5;
   localparam logic [SPR_W-1:0] SPR_SCLERA_UP   = 4'd6;
   localparam logic [SPR_W-1:0] SPR_SCLERA_DOWN = 4'd7;
   localparam logic [SPR_W-1:0] SPR_SCLERA_LEFT = 4'd8;
   localparam logic [SPR_W-1:0] SPR_SCLERA_RIGHT= 4'd9;
   localparam logic [SPR_W-1:0] SPR_EYE_UP      = 4'd10;
   localparam logic [SPR_W-1:0] SPR_EYE_DOWN    = 4'd11;
   localparam logic [SPR_W-1:0] SPR_EYE_LEFT    = 4'd12;
   localparam logic [SPR_W-1:0] SPR_EYE_RIGHT   = 4'd13;

   localparam logic [1:0] REQ_PAC   = 2'd0;
   localparam logic [1:0] REQ_GHOST = 2'd1;
   localparam logic [1:0] REQ_DOT   = 2'd2;
   localparam logic [1:0] REQ_HUD   = 2'd3;

endpackage

// File: rtl/sprite_resp_fifo.sv
// Two-entry in-order response buffer; a push and a pop may share a cycle,
// including when full (the freed slot takes the new entry).
module sprite_resp_fifo
   import pac_sprite_pkg::*;
#(
   parameter int W = 18
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [1:0]   count,
   output logic [W-1:0] head
);

   logic [W-1:0] mem [2];
   logic         wr_ptr, rd_ptr;
   logic         pop_ok;

   assign pop_ok = pop & (count != 2'd0);
   assign head   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) mem[i] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
`ifndef SYNTHESIS
         assert (!(push && count == 2'd2 && !pop_ok));
`endif
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop_ok) rd_ptr <= ~rd_ptr;
         count <= count + 2'(push) - 2'(pop_ok);
      end
   end

endmodule

// File: rtl/sprite_row_fetch_arbiter.sv
// Round-robin arbiter sharing one registered-output sprite ROM between render
// requesters; rows (optionally mirrored) return through a 2-entry buffer.
module sprite_row_fetch_arbiter
   import pac_sprite_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int TILE_SIZE = pac_sprite_pkg::TILE_SIZE,
   parameter int SPR_W     = pac_sprite_pkg::SPR_W,
   parameter int ROW_W     = pac_sprite_pkg::ROW_W,
   parameter int ID_W      = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*SPR_W-1:0] req_sprite,
   input  logic [NUM_REQ*ROW_W-1:0] req_row,
   input  logic [NUM_REQ-1:0]       req_flip,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     rom_en,
   output logic [SPR_W+ROW_W-1:0]   rom_addr,
   input  logic [TILE_SIZE-1:0]     rom_data,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [ID_W-1:0]          resp_id,
   output logic [TILE_SIZE-1:0]     resp_bits
);

   logic [ID_W-1:0]      rr_ptr, win, inf_id;
   logic                 inflight, inf_flip;
   logic                 found, can_issue, grant, pop;
   logic [1:0]           count;
   logic [2:0]           credit;
   logic [TILE_SIZE-1:0] rev_row, push_row;
   int                   idx;

   // Credit counts buffered rows plus the one in the ROM pipe; a same-cycle
   // pop frees a slot so streaming sustains one grant per cycle.
   assign pop       = resp_valid & resp_ready;
   assign credit    = 3'(count) + 3'(inflight) - 3'(pop);
   assign can_issue = credit < 3'd2;

   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = ID_W'(idx);
         end
      end
   end

   assign grant     = ~rst & can_issue & found;
   assign req_ready = grant ? (NUM_REQ'(1) << win) : '0;
   assign rom_en    = grant;
   assign rom_addr  = {req_sprite[int'(win)*SPR_W +: SPR_W],
                       req_row[int'(win)*ROW_W +: ROW_W]};

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr   <= '0;
         inflight <= 1'b0;
         inf_id   <= '0;
         inf_flip <= 1'b0;
      end else begin
         inflight <= grant;
         if (grant) begin
            rr_ptr   <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
            inf_id   <= win;
            inf_flip <= req_flip[win];
         end
      end
   end

   for (genvar j = 0; j < TILE_SIZE; j++) begin : g_rev
      assign rev_row[j] = rom_data[TILE_SIZE-1-j];
   end

   assign push_row   = inf_flip ? rev_row : rom_data;
   assign resp_valid = (count != 2'd0);

   sprite_resp_fifo #(.W(ID_W + TILE_SIZE)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight),
      .push_data ({inf_id, push_row}),
      .pop       (pop),
      .count     (count),
      .head      ({resp_id, resp_bits})
   );

endmodule

// File: tb/tb_sprite_row_fetch_arbiter.sv
// Directed bench: cycle vector tables for fetch/mirror/round-robin plus
// hand-written reset, backpressure and mid-flight reset sequences.
module tb_sprite_row_fetch_arbiter;

   localparam int NUM_REQ = 4;
   localparam int TS      = 16;
   localparam int SPR_W   = 4;
   localparam int ROW_W   = 4;
   localparam int ID_W    = 2;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*SPR_W-1:0] req_sprite;
   logic [NUM_REQ*ROW_W-1:0] req_row;
   logic [NUM_REQ-1:0]       req_flip;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     rom_en;
   logic [SPR_W+ROW_W-1:0]   rom_addr;
   logic [TS-1:0]            rom_data;
   logic                     resp_valid;
   logic                     resp_ready;
   logic [ID_W-1:0]          resp_id;
   logic [TS-1:0]            resp_bits;

   int checks = 0;
   int errors = 0;

   sprite_row_fetch_arbiter #(
      .NUM_REQ(NUM_REQ), .TILE_SIZE(TS), .SPR_W(SPR_W), .ROW_W(ROW_W), .ID_W(ID_W)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_sprite(req_sprite),
      .req_row(req_row), .req_flip(req_flip), .req_ready(req_ready),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_bits(resp_bits)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  rv;
      logic [3:0]  flip;
      logic        rr;
      logic [15:0] rdata;
      logic [3:0]  e_ready;
      logic        e_en;
      logic [7:0]  e_addr;
      logic        e_vld;
      logic [1:0]  e_id;
      logic [15:0] e_bits;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void add(input logic [3:0] rv, input logic [3:0] flip, input logic rr,
                               input logic [15:0] rdata, input logic [3:0] e_ready,
                               input logic e_en, input logic [7:0] e_addr, input logic e_vld,
                               input logic [1:0] e_id, input logic [15:0] e_bits);
      vec_t v;
      v.rv = rv; v.flip = flip; v.rr = rr; v.rdata = rdata; v.e_ready = e_ready;
      v.e_en = e_en; v.e_addr = e_addr; v.e_vld = e_vld; v.e_id = e_id; v.e_bits = e_bits;
      vq.push_back(v);
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Each vector covers one clock: drive, settle, compare, advance.
   task automatic run_vecs(input string tag);
      for (int i = 0; i < vq.size(); i++) begin
         req_valid  = vq[i].rv;
         req_flip   = vq[i].flip;
         resp_ready = vq[i].rr;
         rom_data   = vq[i].rdata;
         #1;
         chk($sformatf("%s[%0d].ready", tag, i), 32'(req_ready), 32'(vq[i].e_ready));
         chk($sformatf("%s[%0d].rom_en", tag, i), 32'(rom_en), 32'(vq[i].e_en));
         if (vq[i].e_en)
            chk($sformatf("%s[%0d].addr", tag, i), 32'(rom_addr), 32'(vq[i].e_addr));
         chk($sformatf("%s[%0d].vld", tag, i), 32'(resp_valid), 32'(vq[i].e_vld));
         if (vq[i].e_vld) begin
            chk($sformatf("%s[%0d].id", tag, i), 32'(resp_id), 32'(vq[i].e_id));
            chk($sformatf("%s[%0d].bits", tag, i), 32'(resp_bits), 32'(vq[i].e_bits));
         end
         cyc();
      end
      vq.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = '0; req_flip = '0; resp_ready = 1'b0; rom_data = '0;
      cyc();
      rst = 1'b0;
   endtask

   int gcnt;

   initial begin
      rst = 1'b1; req_valid = 4'hF; req_flip = '0; resp_ready = 1'b1; rom_data = '0;
      req_sprite = '0; req_row = '0;

      // Reset held 2 cycles with every requester pending.
      #1;
      chk("rst0.ready", 32'(req_ready), 32'h0);
      chk("rst0.rom_en", 32'(rom_en), 32'h0);
      cyc();
      chk("rst1.ready", 32'(req_ready), 32'h0);
      chk("rst1.rom_en", 32'(rom_en), 32'h0);
      chk("rst1.vld", 32'(resp_valid), 32'h0);
      chk("rst1.id", 32'(resp_id), 32'h0);
      chk("rst1.bits", 32'(resp_bits), 32'h0);
      cyc();
      chk("rst2.vld", 32'(resp_valid), 32'h0);
      rst = 1'b0;
      #1;
      chk("first.ready", 32'(req_ready), 32'h1);
      chk("first.rom_en", 32'(rom_en), 32'h1);
      cyc();
      req_valid = '0;
      for (int i = 0; i < 3; i++) cyc();

      // Single fetch then mirrored fetches from requester 2.
      do_reset();
      req_sprite = {4'h0, 4'h3, 4'h0, 4'h0};
      req_row    = {4'h0, 4'h5, 4'h0, 4'h0};
      add(4'b0100, 4'b0000, 1, 16'h0000, 4'b0100, 1, 8'h35, 0, 2'd0, 16'h0000);
      add(4'b0000, 4'b0000, 1, 16'hF00F, 4'b0000, 0, 8'h00, 0, 2'd0, 16'h0000);
      add(4'b0000, 4'b0000, 1, 16'h0000, 4'b0000, 0, 8'h00, 1, 2'd2, 16'hF00F);
      add(4'b0000, 4'b0000, 1, 16'h0000, 4'b0000, 0, 8'h00, 0, 2'd0, 16'h0000);
      run_vecs("single");
      add(4'b0100, 4'b0100, 1, 16'h0000, 4'b0100, 1, 8'h35, 0, 2'd0, 16'h0000);
      add(4'b0100, 4'b0100, 1, 16'h8001, 4'b0100, 1, 8'h35, 0, 2'd0, 16'h0000);
      add(4'b0000, 4'b0000, 1, 16'h000F, 4'b0000, 0, 8'h00, 1, 2'd2, 16'h8001);
      add(4'b0000, 4'b0000, 1, 16'h0000, 4'b0000, 0, 8'h00, 1, 2'd2, 16'hF000);
      add(4'b0000, 4'b0000, 1, 16'h0000, 4'b0000, 0, 8'h00, 0, 2'd0, 16'h0000);
      run_vecs("mirror");

      // Round-robin streaming with all four requesters pending.
      do_reset();
      req_sprite = {4'h7, 4'h6, 4'h5, 4'h4};
      req_row    = {4'h3, 4'h2, 4'h1, 4'h0};
      add(4'hF, 4'h0, 1, 16'h0000, 4'b0001, 1, 8'h40, 0, 2'd0, 16'h0000);
      add(4'hF, 4'h0, 1, 16'hA000, 4'b0010, 1, 8'h51, 0, 2'd0, 16'h0000);
      add(4'hF, 4'h0, 1, 16'hA001, 4'b0100, 1, 8'h62, 1, 2'd0, 16'hA000);
      add(4'hF, 4'h0, 1, 16'hA002, 4'b1000, 1, 8'h73, 1, 2'd1, 16'hA001);
      add(4'hF, 4'h0, 1, 16'hA003, 4'b0001, 1, 8'h40, 1, 2'd2, 16'hA002);
      add(4'hF, 4'h0, 1, 16'hA004, 4'b0010, 1, 8'h51, 1, 2'd3, 16'hA003);
      add(4'h0, 4'h0, 1, 16'hA005, 4'b0000, 0, 8'h00, 1, 2'd0, 16'hA004);
      add(4'h0, 4'h0, 1, 16'h0000, 4'b0000, 0, 8'h00, 1, 2'd1, 16'hA005);
      add(4'h0, 4'h0, 1, 16'h0000, 4'b0000, 0, 8'h00, 0, 2'd0, 16'h0000);
      run_vecs("rr");

      // Backpressure: two grants fill the credit, one pop re-opens one slot.
      do_reset();
      req_valid = 4'b0010; resp_ready = 1'b0; gcnt = 0;
      for (int c = 0; c < 5; c++) begin
         rom_data = (c == 1) ? 16'h1111 : (c == 2) ? 16'h2222 : 16'h0000;
         #1;
         if (req_ready != '0) gcnt++;
         if (c >= 2) begin
            chk($sformatf("bp%0d.ready", c), 32'(req_ready), 32'h0);
            chk($sformatf("bp%0d.bits", c), 32'(resp_bits), 32'h1111);
         end
         cyc();
      end
      chk("bp.grants", 32'(gcnt), 32'd2);
      resp_ready = 1'b1; rom_data = '0;
      #1;
      chk("bp.pop_grant", 32'(req_ready), 32'b0010);
      chk("bp.pop_head", 32'(resp_bits), 32'h1111);
      cyc();
      resp_ready = 1'b0; req_valid = '0; rom_data = 16'h3333;
      #1;
      chk("bp.after_ready", 32'(req_ready), 32'h0);
      chk("bp.after_head", 32'(resp_bits), 32'h2222);
      cyc();
      resp_ready = 1'b1; rom_data = '0;
      #1;
      chk("bp.drain0", 32'(resp_bits), 32'h2222);
      cyc();
      #1;
      chk("bp.drain1.vld", 32'(resp_valid), 32'h1);
      chk("bp.drain1", 32'(resp_bits), 32'h3333);
      cyc();
      #1;
      chk("bp.empty", 32'(resp_valid), 32'h0);
      cyc();

      // Reset the cycle after a grant: the read is dropped and credit is full.
      do_reset();
      req_valid = 4'b0001; resp_ready = 1'b1;
      #1;
      chk("mf.grant", 32'(req_ready), 32'h1);
      cyc();
      rst = 1'b1; req_valid = '0; rom_data = 16'hDEAD;
      #1;
      chk("mf.rst_ready", 32'(req_ready), 32'h0);
      chk("mf.rst_en", 32'(rom_en), 32'h0);
      cyc();
      rst = 1'b0; rom_data = '0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("mf.novld%0d", c), 32'(resp_valid), 32'h0);
         cyc();
      end
      resp_ready = 1'b0; req_valid = 4'b0001;
      #1;
      chk("mf.cred0", 32'(req_ready), 32'h1);
      cyc();
      #1;
      chk("mf.cred1", 32'(req_ready), 32'h1);
      cyc();
      #1;
      chk("mf.cred2", 32'(req_ready), 32'h0);
      req_valid = '0; resp_ready = 1'b1;
      for (int c = 0; c < 3; c++) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
